// File: rtl/zxbus_io_responder.sv
// ZX-bus I/O responder: decodes its own port window on the asynchronous
// Z80 expansion bus, claims the cycle through the IORQGE daisy chain,
// serves reads through a req/ack handshake with internal logic and turns
// bus writes into single-cycle strobes.
module zxbus_io_responder #(
  parameter logic [7:0] PORT_LO    = 8'hAF,
  parameter int         IDX_BITS   = 2,
  parameter int         RD_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         zx_a,
  input  logic [7:0]          zx_d_in,
  output logic [7:0]          zx_d_out,
  output logic                zx_d_oe,
  input  logic                zx_iorq_n,
  input  logic                zx_rd_n,
  input  logic                zx_wr_n,
  input  logic                zx_m1_n,
  input  logic                iorqge_in,
  output logic                iorqge_out,
  output logic                wr_stb,
  output logic [IDX_BITS-1:0] wr_idx,
  output logic [7:0]          wr_data,
  output logic                rd_req,
  output logic [IDX_BITS-1:0] rd_idx,
  input  logic [7:0]          rd_data,
  input  logic                rd_ack
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_CAP,
    HOLD
  } state_t;

  state_t state, state_d;

  logic iorq_s1, iorq_s2;
  logic rd_s1, rd_s2;
  logic wr_s1, wr_s2;
  logic m1_s1, m1_s2;

  logic io_act, io_act_q, io_filt;
  logic hit;
  logic [IDX_BITS-1:0] bus_idx;

  logic [1:0] warm;
  logic lockout;

  logic claim, claim_d;
  logic rd_req_d;
  logic [7:0] d_out_d;
  logic wr_stb_d;
  logic [7:0] wr_data_d;
  logic [IDX_BITS-1:0] wr_idx_d, rd_idx_d;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_d;
  logic wr_wait, wr_wait_d;

  // Address bits above the register index carry no meaning for this device.
  logic unused_addr_bits;
  assign unused_addr_bits = ^zx_a[15:8+IDX_BITS];

  // Two-flop synchronisers for the bus strobes; they rest at the inactive level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iorq_s1 <= 1'b1;
      iorq_s2 <= 1'b1;
      rd_s1   <= 1'b1;
      rd_s2   <= 1'b1;
      wr_s1   <= 1'b1;
      wr_s2   <= 1'b1;
      m1_s1   <= 1'b1;
      m1_s2   <= 1'b1;
    end else begin
      iorq_s1 <= zx_iorq_n;
      iorq_s2 <= iorq_s1;
      rd_s1   <= zx_rd_n;
      rd_s2   <= rd_s1;
      wr_s1   <= zx_wr_n;
      wr_s2   <= wr_s1;
      m1_s1   <= zx_m1_n;
      m1_s2   <= m1_s1;
    end
  end

  // An I/O access is IORQ low with RD or WR low, but never an interrupt acknowledge.
  assign io_act  = !iorq_s2 && m1_s2 && (!rd_s2 || !wr_s2);
  assign io_filt = io_act && io_act_q;

  // The address is already stable by the time the filtered access is seen.
  assign hit     = (zx_a[7:0] == PORT_LO);
  assign bus_idx = zx_a[8 +: IDX_BITS];

  // Glitch filter history and post-reset lockout. The synchronisers read as
  // idle straight after reset, so the lockout only trusts an IORQ-high
  // observation once real samples have propagated through both flops; this
  // keeps a bus cycle already in progress at reset from being claimed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_act_q <= 1'b0;
      warm     <= 2'b00;
      lockout  <= 1'b1;
    end else begin
      io_act_q <= io_act;
      warm     <= {warm[0], 1'b1};
      if (warm[1] && iorq_s2) begin
        lockout <= 1'b0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      claim    <= 1'b0;
      rd_req   <= 1'b0;
      zx_d_out <= 8'hFF;
      wr_stb   <= 1'b0;
      wr_data  <= 8'h00;
      wr_idx   <= '0;
      rd_idx   <= '0;
      rd_cnt   <= '0;
      wr_wait  <= 1'b0;
    end else begin
      state    <= state_d;
      claim    <= claim_d;
      rd_req   <= rd_req_d;
      zx_d_out <= d_out_d;
      wr_stb   <= wr_stb_d;
      wr_data  <= wr_data_d;
      wr_idx   <= wr_idx_d;
      rd_idx   <= rd_idx_d;
      rd_cnt   <= rd_cnt_d;
      wr_wait  <= wr_wait_d;
    end
  end

  // Next-state and next-output logic for one bus access per IORQ cycle.
  always_comb begin
    state_d   = state;
    claim_d   = claim;
    rd_req_d  = rd_req;
    d_out_d   = zx_d_out;
    wr_stb_d  = 1'b0;
    wr_data_d = wr_data;
    wr_idx_d  = wr_idx;
    rd_idx_d  = rd_idx;
    rd_cnt_d  = rd_cnt;
    wr_wait_d = wr_wait;

    case (state)
      IDLE: begin
        rd_cnt_d  = '0;
        wr_wait_d = 1'b0;
        if (io_filt && !lockout) begin
          if (!hit) begin
            state_d = HOLD;
          end else if (!rd_s2) begin
            state_d  = RD_WAIT;
            claim_d  = 1'b1;
            rd_req_d = 1'b1;
            rd_idx_d = bus_idx;
          end else begin
            state_d  = WR_CAP;
            claim_d  = 1'b1;
            wr_idx_d = bus_idx;
          end
        end
      end

      RD_WAIT: begin
        if (iorq_s2) begin
          state_d  = IDLE;
          claim_d  = 1'b0;
          rd_req_d = 1'b0;
        end else if (rd_ack) begin
          d_out_d  = rd_data;
          rd_req_d = 1'b0;
          state_d  = RD_DRIVE;
        end else if (rd_cnt == CNT_LAST) begin
          d_out_d  = 8'hFF;
          rd_req_d = 1'b0;
          state_d  = RD_DRIVE;
        end else begin
          rd_cnt_d = rd_cnt + CNT_W'(1);
        end
      end

      RD_DRIVE: begin
        if (rd_s2) begin
          state_d = HOLD;
        end
      end

      WR_CAP: begin
        if (iorq_s2) begin
          state_d = IDLE;
          claim_d = 1'b0;
        end else if (wr_wait) begin
          wr_data_d = zx_d_in;
          wr_stb_d  = 1'b1;
          state_d   = HOLD;
        end else if (!wr_s2) begin
          wr_wait_d = 1'b1;
        end
      end

      HOLD: begin
        if (iorq_s2) begin
          claim_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        claim_d  = 1'b0;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // Data is driven only while the master holds RD low in the drive phase,
  // so the enable drops within two edges of RD rising.
  assign zx_d_oe = (state == RD_DRIVE) && !rd_s2;

  // Downstream claims pass straight through, independent of reset.
  assign iorqge_out = iorqge_in | claim;

endmodule

// File: tb/tb_zxbus_io_responder.sv
// Self-checking bench for zxbus_io_responder: a latency-level model of the
// bus protocol is compared against the DUT every clock, with literal checks
// pinning the key values of each directed scenario.
module tb_zxbus_io_responder;

  localparam int RD_TIMEOUT = 16;
  localparam int BIG = 1 << 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] zx_a = 16'h0000;
  logic [7:0] zx_d_in = 8'h00;
  logic [7:0] zx_d_out;
  logic zx_d_oe;
  logic zx_iorq_n = 1'b1;
  logic zx_rd_n = 1'b1;
  logic zx_wr_n = 1'b1;
  logic zx_m1_n = 1'b1;
  logic iorqge_in = 1'b0;
  logic iorqge_out;
  logic wr_stb;
  logic [1:0] wr_idx;
  logic [7:0] wr_data;
  logic rd_req;
  logic [1:0] rd_idx;
  logic [7:0] rd_data = 8'h00;
  logic rd_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Current bus cycle as seen by the model: edge numbers where the DUT first
  // samples each event.
  int m_k = BIG, m_r = BIG, m_rdr = BIG, m_ack = BIG, m_kill = BIG;
  bit m_hit = 1'b0, m_read = 1'b0, m_timeout = 1'b0;
  logic [7:0] m_data = 8'hFF;
  logic [7:0] m_wdata = 8'h00;
  logic [1:0] m_idx = 2'd0;

  int req_rises = 0, req_cycles = 0, stb_pulses = 0;
  logic req_prev = 1'b0;
  bit rand_ge = 1'b0;

  zxbus_io_responder #(
    .PORT_LO(8'hAF),
    .IDX_BITS(2),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .zx_a(zx_a),
    .zx_d_in(zx_d_in),
    .zx_d_out(zx_d_out),
    .zx_d_oe(zx_d_oe),
    .zx_iorq_n(zx_iorq_n),
    .zx_rd_n(zx_rd_n),
    .zx_wr_n(zx_wr_n),
    .zx_m1_n(zx_m1_n),
    .iorqge_in(iorqge_in),
    .iorqge_out(iorqge_out),
    .wr_stb(wr_stb),
    .wr_idx(wr_idx),
    .wr_data(wr_data),
    .rd_req(rd_req),
    .rd_idx(rd_idx),
    .rd_data(rd_data),
    .rd_ack(rd_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Expected outputs after edge n, from the protocol latencies: claim four
  // edges after IORQ is first sampled low, strobe on the sixth, read data the
  // edge the ack is sampled, timeout after RD_TIMEOUT edges of waiting,
  // release two edges after the strobe that ends each phase is sampled high.
  function automatic void model_at(input int n, output logic claim_e, output logic req_e,
                                   output logic oe_e, output logic stb_e);
    int done;
    claim_e = 1'b0;
    req_e   = 1'b0;
    oe_e    = 1'b0;
    stb_e   = 1'b0;
    if (m_hit && n < m_kill) begin
      if (m_read) begin
        done = m_timeout ? m_k + 3 + RD_TIMEOUT : m_ack;
        if (m_r + 2 <= done) begin
          claim_e = (n >= m_k + 3) && (n < m_r + 2);
          req_e   = claim_e;
        end else begin
          claim_e = (n >= m_k + 3) && (n < imax(m_r + 2, m_rdr + 3));
          req_e   = (n >= m_k + 3) && (n < done);
          oe_e    = (n >= done) && (n < m_rdr + 1);
        end
      end else if (m_r + 2 <= m_k + 5) begin
        claim_e = (n >= m_k + 3) && (n < m_r + 2);
      end else begin
        claim_e = (n >= m_k + 3) && (n < imax(m_r + 2, m_k + 6));
        stb_e   = (n == m_k + 5);
      end
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    logic claim_e, req_e, oe_e, stb_e;
    cyc = cyc + 1;
    #2;
    model_at(cyc, claim_e, req_e, oe_e, stb_e);
    checkOutput("iorqge_out", iorqge_out, iorqge_in | claim_e);
    checkOutput("rd_req", rd_req, req_e);
    checkOutput("zx_d_oe", zx_d_oe, oe_e);
    checkOutput("wr_stb", wr_stb, stb_e);
    if (oe_e) checkOutput("zx_d_out", zx_d_out, m_data);
    if (req_e) checkOutput("rd_idx", rd_idx, m_idx);
    if (stb_e) begin
      checkOutput("wr_data", wr_data, m_wdata);
      checkOutput("wr_idx", wr_idx, m_idx);
    end
    if (rd_req === 1'b1 && req_prev !== 1'b1) req_rises++;
    if (rd_req === 1'b1) req_cycles++;
    if (wr_stb === 1'b1) stb_pulses++;
    req_prev = rd_req;
  end

  // Random downstream IORQGE activity while enabled.
  always @(negedge clk) begin
    if (rand_ge) iorqge_in = 1'($urandom_range(0, 1));
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Starts a bus cycle at the current negedge and records it in the model.
  task automatic applyStimulus(input logic [15:0] addr, input bit do_rd, input bit do_wr,
                               input bit m1, input logic [7:0] din);
    zx_a      = addr;
    zx_d_in   = din;
    zx_m1_n   = m1;
    zx_iorq_n = 1'b0;
    zx_rd_n   = !do_rd;
    zx_wr_n   = !do_wr;
    m_k       = cyc + 1;
    m_r       = BIG;
    m_rdr     = BIG;
    m_ack     = BIG;
    m_kill    = BIG;
    m_timeout = 1'b0;
    m_hit     = (addr[7:0] == 8'hAF) && m1 && (do_rd || do_wr);
    m_read    = do_rd;
    m_idx     = addr[9:8];
    m_wdata   = din;
  endtask

  task automatic endBus();
    zx_iorq_n = 1'b1;
    zx_rd_n   = 1'b1;
    zx_wr_n   = 1'b1;
    zx_m1_n   = 1'b1;
    m_r       = cyc + 1;
    m_rdr     = cyc + 1;
  endtask

  task automatic waitReq(input logic level, input int limit, input string name);
    int i = 0;
    while (rd_req !== level && i < limit) begin
      step();
      i++;
    end
    checkOutput(name, rd_req, level);
  endtask

  task automatic giveAck(input logic [7:0] d, input int delay);
    step(delay);
    rd_data = d;
    rd_ack  = 1'b1;
    m_ack   = cyc + 1;
    m_data  = d;
    step();
    rd_ack  = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_d_out"}, zx_d_out, 8'hFF);
    checkOutput({tag, "_oe"}, zx_d_oe, 1'b0);
    checkOutput({tag, "_rd_req"}, rd_req, 1'b0);
    checkOutput({tag, "_rd_idx"}, rd_idx, 2'd0);
    checkOutput({tag, "_wr_stb"}, wr_stb, 1'b0);
    checkOutput({tag, "_wr_idx"}, wr_idx, 2'd0);
    checkOutput({tag, "_wr_data"}, wr_data, 8'h00);
  endtask

  initial begin
    // Reset, with IORQGE passing through while reset is held.
    iorqge_in = 1'b1;
    step(3);
    checkOutput("ge_in_reset", iorqge_out, 1'b1);
    checkResetValues("rst0");
    iorqge_in = 1'b0;
    rst_n = 1'b1;
    step(4);

    // 1: read, ack three cycles after the request.
    req_rises = 0;
    step();
    applyStimulus(16'h01AF, 1'b1, 1'b0, 1'b1, 8'h00);
    waitReq(1'b1, 10, "t1_rd_req_rise");
    checkOutput("t1_rd_idx", rd_idx, 2'd1);
    checkOutput("t1_iorqge", iorqge_out, 1'b1);
    giveAck(8'h5A, 2);
    step(2);
    checkOutput("t1_d_out", zx_d_out, 8'h5A);
    checkOutput("t1_oe", zx_d_oe, 1'b1);
    endBus();
    step(8);
    checkOutput("t1_req_rises", req_rises, 1);
    checkOutput("t1_oe_released", zx_d_oe, 1'b0);

    // 2: write.
    stb_pulses = 0;
    req_rises = 0;
    step();
    applyStimulus(16'h02AF, 1'b0, 1'b1, 1'b1, 8'hC3);
    step(8);
    endBus();
    step(8);
    checkOutput("t2_stb_pulses", stb_pulses, 1);
    checkOutput("t2_wr_data", wr_data, 8'hC3);
    checkOutput("t2_wr_idx", wr_idx, 2'd2);
    checkOutput("t2_req_rises", req_rises, 0);

    // 3: miss, INTA and M1-low read on our port, with random downstream IORQGE.
    stb_pulses = 0;
    req_rises = 0;
    rand_ge = 1'b1;
    step();
    applyStimulus(16'h01FE, 1'b1, 1'b0, 1'b1, 8'h00);
    step(8);
    endBus();
    step(4);
    applyStimulus(16'h00AF, 1'b0, 1'b0, 1'b0, 8'h00);
    step(8);
    endBus();
    step(4);
    applyStimulus(16'h01AF, 1'b1, 1'b0, 1'b0, 8'h00);
    step(8);
    endBus();
    step(4);
    rand_ge = 1'b0;
    iorqge_in = 1'b0;
    step(2);
    checkOutput("t3_req_rises", req_rises, 0);
    checkOutput("t3_stb_pulses", stb_pulses, 0);

    // 4: read timeout, then a late ack.
    step();
    applyStimulus(16'h03AF, 1'b1, 1'b0, 1'b1, 8'h00);
    m_timeout = 1'b1;
    m_data = 8'hFF;
    req_cycles = 0;
    waitReq(1'b1, 10, "t4_rd_req_rise");
    waitReq(1'b0, 30, "t4_rd_req_drop");
    checkOutput("t4_req_cycles", req_cycles, RD_TIMEOUT);
    step(2);
    checkOutput("t4_d_out", zx_d_out, 8'hFF);
    checkOutput("t4_oe", zx_d_oe, 1'b1);
    rd_data = 8'h11;
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    step(2);
    checkOutput("t4_late_ack_d_out", zx_d_out, 8'hFF);
    endBus();
    step(8);

    // 5a: abort in RD_WAIT, then a normal read.
    step();
    applyStimulus(16'h01AF, 1'b1, 1'b0, 1'b1, 8'h00);
    waitReq(1'b1, 10, "t5_rd_req_rise");
    step(2);
    endBus();
    step(8);
    checkOutput("t5_abort_req", rd_req, 1'b0);
    checkOutput("t5_abort_claim", iorqge_out, 1'b0);
    applyStimulus(16'h02AF, 1'b1, 1'b0, 1'b1, 8'h00);
    waitReq(1'b1, 10, "t5_next_rd_req");
    giveAck(8'h3C, 0);
    step(2);
    checkOutput("t5_next_d_out", zx_d_out, 8'h3C);
    endBus();
    step(8);

    // 5b: reset mid-read, lockout until a fresh IORQ, then a normal read.
    step();
    applyStimulus(16'h03AF, 1'b1, 1'b0, 1'b1, 8'h00);
    waitReq(1'b1, 10, "t5_rst_rd_req");
    step(2);
    rst_n = 1'b0;
    m_kill = cyc + 1;
    step();
    rst_n = 1'b1;
    checkResetValues("rst1");
    step(8);
    checkOutput("t5_lockout_claim", iorqge_out, 1'b0);
    checkOutput("t5_lockout_req", rd_req, 1'b0);
    endBus();
    step(6);
    applyStimulus(16'h01AF, 1'b1, 1'b0, 1'b1, 8'h00);
    waitReq(1'b1, 10, "t5_fresh_rd_req");
    giveAck(8'h96, 1);
    step(2);
    checkOutput("t5_fresh_d_out", zx_d_out, 8'h96);
    endBus();
    step(8);

    // 6: one-clock IORQ glitch on a matching address.
    req_rises = 0;
    stb_pulses = 0;
    step();
    applyStimulus(16'h01AF, 1'b1, 1'b0, 1'b1, 8'h00);
    step();
    zx_iorq_n = 1'b1;
    m_r = cyc + 1;
    step(3);
    zx_rd_n = 1'b1;
    step(6);
    checkOutput("t6_req_rises", req_rises, 0);
    checkOutput("t6_stb_pulses", stb_pulses, 0);
    checkOutput("t6_claim", iorqge_out, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/zxbus_io_responder.md
# zxbus_io_responder

Peripheral-side responder for ZX-bus I/O cycles. A bus master generates IORQ, and devices on the expansion bus claim cycles through the daisy-chained IORQGE line. This block is the slave end: it samples the asynchronous Z80 bus in the `clk` domain and decodes its own port window. On a hit it asserts IORQGE upstream, serves reads from internal logic through a request/acknowledge handshake, and delivers writes as single-cycle strobes.

## Interface
Parameters:
- `PORT_LO`, 8'hAF: required value of `zx_a[7:0]`.
- `IDX_BITS`, 2: register index width, taken from `zx_a[8+IDX_BITS-1:8]`. Address bits above the index are don't-care.
- `RD_TIMEOUT`, 16: maximum `clk` cycles to wait for `rd_ack` before returning 8'hFF.

Ports:
- `clk`, in, 1: system clock. Must be at least 4x the Z80 clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `zx_a`, in, 16: bus address, asynchronous.
- `zx_d_in`, in, 8: bus data toward the device.
- `zx_d_out`, out, 8: read data.
- `zx_d_oe`, out, 1: data output enable.
- `zx_iorq_n`, `zx_rd_n`, `zx_wr_n`, `zx_m1_n`, in, 1 each: bus strobes, asynchronous.
- `iorqge_in`, in, 1: IORQGE from the downstream device.
- `iorqge_out`, out, 1: IORQGE toward the master. Equal to `iorqge_in | claim`.
- `wr_stb`, out, 1: one-cycle write strobe.
- `wr_idx`, out, `IDX_BITS`: write register index.
- `wr_data`, out, 8: write data.
- `rd_req`, out, 1: read request. Level signal, held until `rd_ack` or abort.
- `rd_idx`, out, `IDX_BITS`: read register index.
- `rd_data`, in, 8: read data from internal logic.
- `rd_ack`, in, 1: read data valid. Sampled only while `rd_req` is high.

## Operation
- **Input synchronisation.** `zx_iorq_n`, `zx_rd_n`, `zx_wr_n` and `zx_m1_n` each pass through a 2-flop synchroniser (s1, s2).
- **Active cycle definition.** `io_act = !iorq_s2 && m1_s2 && (!rd_s2 || !wr_s2)`. Cycles with M1 low (INTA) are never claimed.
- **Glitch filter.** `io_act` must be true for 2 consecutive `clk` cycles before it counts.
- **Address decode.** `zx_a` is sampled directly in the filter cycle; the bus address is stable by then. The cycle is a hit when `zx_a[7:0] == PORT_LO`. The index is latched at the same time.
- **States:** IDLE, RD_WAIT, RD_DRIVE, WR_CAP, HOLD.
- **IDLE.**
  - Filtered `io_act` with a hit and RD low: set `claim`, enter RD_WAIT, raise `rd_req`.
  - Filtered `io_act` with a hit and WR low: set `claim`, enter WR_CAP.
  - Filtered `io_act` with no hit: enter HOLD with `claim`=0.
- **RD_WAIT.**
  - `rd_ack`: latch `rd_data` into `zx_d_out`, drop `rd_req`, enter RD_DRIVE.
  - Timeout counter reaches `RD_TIMEOUT`: load 8'hFF into `zx_d_out`, drop `rd_req`, enter RD_DRIVE.
- **RD_DRIVE.** `zx_d_oe` = `!rd_s2`. Enter HOLD when `rd_s2` goes high.
- **WR_CAP.** Wait one further cycle with `wr_s2` low so data is settled. Capture `zx_d_in` into `wr_data`, pulse `wr_stb` for exactly 1 cycle, enter HOLD.
- **HOLD.** Keep `claim` until `iorq_s2` is high, then clear `claim`, clear `zx_d_oe` and return to IDLE. HOLD guarantees exactly one access per bus cycle.
- **Abort.** If `iorq_s2` goes high in RD_WAIT or WR_CAP, return to IDLE immediately:
  - drop `rd_req` and `claim`;
  - a late `rd_ack` is ignored;
  - no `wr_stb` is issued.
- **Downstream pass-through.** `iorqge_in` always propagates to `iorqge_out`, regardless of state or reset.

## Timing
- **Reset values:** state IDLE, `claim`=0, `zx_d_oe`=0, `zx_d_out`=8'hFF, `wr_stb`=0, `wr_data`=0, `wr_idx`=0, `rd_req`=0, `rd_idx`=0, timeout counter 0, synchroniser flops at 1 (inactive).
- **Reset mid-cycle.** Reset during a cycle forces the reset values on the next edge. After reset release, the block does not re-claim the bus cycle in progress until IORQ has been seen high; it starts in a HOLD-like lockout. See test case 5.
- **Claim latency.** `claim`, and therefore `iorqge_out`, rises 4 `clk` edges after `zx_iorq_n` falls: 2 sync + 2 filter.
- **Read data.** Available on `zx_d_out` the cycle after `rd_ack`. `zx_d_oe` never rises before `zx_d_out` is valid.
- **Write strobe.** `wr_stb` occurs on edge 6 after `zx_wr_n` falls, provided IORQ is already low.
- **Read timeout.** Counts edges in RD_WAIT. After `RD_TIMEOUT` edges the returned data is 8'hFF.
- **Release.** `zx_d_oe` falls at most 2 edges after `zx_rd_n` rises.

## Test plan
1. **Read.** Read from port 16'h01AF with `rd_ack` 3 cycles after `rd_req`, `rd_data`=8'h5A -> `rd_idx`=1, `iorqge_out`=1, `zx_d_out`=8'h5A with `zx_d_oe`=1 until RD rises. Exactly one `rd_req` assertion.
2. **Write.** Write 8'hC3 to port 16'h02AF -> one `wr_stb` pulse with `wr_idx`=2, `wr_data`=8'hC3. `zx_d_oe` stays 0 throughout.
3. **Miss and INTA.** Access to port 16'h01FE, then an INTA cycle (M1 and IORQ low) -> `claim`=0, no `rd_req`, no `wr_stb`. `iorqge_out` follows `iorqge_in` toggled at random.
4. **Timeout.** Read with `rd_ack` never asserted and `RD_TIMEOUT`=16 -> 8'hFF driven after 16 cycles in RD_WAIT. A late `rd_ack` has no effect.
5. **Abort and reset.** IORQ released in RD_WAIT -> `rd_req` and `claim` drop; the next cycle is served normally. Then `rst_n` low for 1 cycle mid-read -> all outputs take their reset values and no claim is made until the next fresh IORQ.
6. **Glitch.** A 1-`clk`-wide IORQ low glitch on a matching address -> no claim and no strobes.
